// File: rtl/fix_out_quant_fifo.sv
// Quantiser and output buffer for the filter result stream.
// Round-half-up, saturate to out_w bits, then queue for a ready/valid consumer.
module fix_out_quant_fifo #(
    parameter int in_w       = 24,
    parameter int out_w      = 14,
    parameter int fifo_depth = 8,
    parameter int cnt_w      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [in_w-1:0]               in_data,
    input  logic                          in_valid,
    output logic [out_w-1:0]              out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(fifo_depth):0]   fill,
    output logic                          ovf_flag,
    output logic [cnt_w-1:0]              ovf_count,
    output logic [cnt_w-1:0]              sat_count,
    input  logic                          clr_stats
);

    localparam int SH = in_w - out_w;
    localparam int PW = $clog2(fifo_depth);
    localparam logic [in_w:0] RND = (in_w+1)'(1) << (SH - 1);
    localparam logic signed [in_w:0] QMAX = $signed({{(in_w-out_w+2){1'b0}}, {(out_w-1){1'b1}}});
    localparam logic signed [in_w:0] QMIN = ~QMAX;

    // Quantiser datapath: sign-extend by one bit so the rounding add cannot overflow.
    logic        [in_w:0]    sum;
    logic signed [in_w:0]    qFull;
    logic                    posSat;
    logic                    negSat;
    logic        [out_w-1:0] qSat;

    always_comb begin
        sum    = {in_data[in_w-1], in_data} + RND;
        qFull  = $signed(sum) >>> SH;
        posSat = qFull > QMAX;
        negSat = qFull < QMIN;
        if (posSat)
            qSat = QMAX[out_w-1:0];
        else if (negSat)
            qSat = QMIN[out_w-1:0];
        else
            qSat = qFull[out_w-1:0];
    end

    logic [out_w-1:0] qData;
    logic             qV;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            qData <= '0;
            qV    <= 1'b0;
        end else begin
            qV <= in_valid;
            if (in_valid)
                qData <= qSat;
        end
    end

    // FIFO with one extra pointer bit to tell full from empty.
    logic [out_w-1:0] mem [fifo_depth];
    logic [PW:0]      wrPtr;
    logic [PW:0]      rdPtr;
    logic             full;
    logic             empty;
    logic             doRead;
    logic             doWrite;
    logic             drop;

    always_comb begin
        empty   = (wrPtr == rdPtr);
        full    = (wrPtr[PW] != rdPtr[PW]) && (wrPtr[PW-1:0] == rdPtr[PW-1:0]);
        doRead  = !empty && out_ready;
        // A same-cycle read frees the slot the write is about to use.
        doWrite = qV && (!full || doRead);
        drop    = qV && full && !doRead;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            for (int i = 0; i < fifo_depth; i++)
                mem[i] <= '0;
        end else begin
            if (doWrite) begin
                mem[wrPtr[PW-1:0]] <= qData;
                wrPtr              <= wrPtr + 1'b1;
            end
            if (doRead)
                rdPtr <= rdPtr + 1'b1;
        end
    end

    assign out_data  = mem[rdPtr[PW-1:0]];
    assign out_valid = !empty;
    assign fill      = wrPtr - rdPtr;

    // Statistics: clear wins over a same-cycle increment; counters stick at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_flag  <= 1'b0;
            ovf_count <= '0;
            sat_count <= '0;
        end else if (clr_stats) begin
            ovf_flag  <= 1'b0;
            ovf_count <= '0;
            sat_count <= '0;
        end else begin
            if (drop) begin
                ovf_flag <= 1'b1;
                if (ovf_count != '1)
                    ovf_count <= ovf_count + 1'b1;
            end
            if (in_valid && (posSat || negSat) && (sat_count != '1))
                sat_count <= sat_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_fix_out_quant_fifo.sv
// Bench for fix_out_quant_fifo: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_fix_out_quant_fifo;

  localparam int IN_W  = 24;
  localparam int OUT_W = 14;
  localparam int DEPTH = 8;
  localparam int CNT_W = 8;
  localparam int SH    = IN_W - OUT_W;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [IN_W-1:0]   in_data;
  logic              in_valid;
  logic [OUT_W-1:0]  out_data;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        fill;
  logic              ovf_flag;
  logic [CNT_W-1:0]  ovf_count;
  logic [CNT_W-1:0]  sat_count;
  logic              clr_stats;

  int tests_run    = 0;
  int tests_failed = 0;

  // reference model state
  logic [OUT_W-1:0] exp_q[$];
  logic [OUT_W-1:0] got_q[$];
  bit               pend_v;
  logic [OUT_W-1:0] pend_d;
  bit               m_ovf_flag;
  int               m_ovf_cnt;
  int               m_sat_cnt;
  int               max_fill;

  fix_out_quant_fifo #(
    .in_w(IN_W), .out_w(OUT_W), .fifo_depth(DEPTH), .cnt_w(CNT_W)
  ) dut (
    .clk(clk), .rst(rst_n), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fill(fill), .ovf_flag(ovf_flag), .ovf_count(ovf_count),
    .sat_count(sat_count), .clr_stats(clr_stats)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // round(x / 2^SH) with halves toward +inf, then clamp to the output range
  function automatic logic [OUT_W-1:0] quant(input logic [IN_W-1:0] d, output bit sat);
    longint x, q, hi, lo;
    x   = longint'($signed(d));
    hi  = (longint'(1) <<< (OUT_W - 1)) - 1;
    lo  = -hi - 1;
    q   = (x + (longint'(1) <<< (SH - 1))) >>> SH;
    sat = 1'b0;
    if (q > hi) begin q = hi; sat = 1'b1; end
    else if (q < lo) begin q = lo; sat = 1'b1; end
    return q[OUT_W-1:0];
  endfunction

  task automatic model_reset();
    exp_q.delete();
    pend_v     = 1'b0;
    pend_d     = '0;
    m_ovf_flag = 1'b0;
    m_ovf_cnt  = 0;
    m_sat_cnt  = 0;
  endtask

  task automatic model_update(input bit v, input logic [IN_W-1:0] d, input bit rdy, input bit clr);
    bit               dropped;
    bit               s;
    logic [OUT_W-1:0] q;
    dropped = 1'b0;
    if (exp_q.size() != 0 && rdy) void'(exp_q.pop_front());
    if (pend_v) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(pend_d);
      else dropped = 1'b1;
    end
    q = quant(d, s);
    if (clr) begin
      m_ovf_flag = 1'b0;
      m_ovf_cnt  = 0;
      m_sat_cnt  = 0;
    end else begin
      if (dropped) begin
        m_ovf_flag = 1'b1;
        if (m_ovf_cnt < CMAX) m_ovf_cnt++;
      end
      if (v && s && m_sat_cnt < CMAX) m_sat_cnt++;
    end
    pend_v = v;
    pend_d = q;
  endtask

  task automatic check_all();
    check_eq("out_valid", out_valid, exp_q.size() != 0);
    check_eq("fill", fill, exp_q.size());
    if (exp_q.size() != 0) check_eq("out_data", out_data, exp_q[0]);
    check_eq("ovf_flag", ovf_flag, m_ovf_flag);
    check_eq("ovf_count", ovf_count, m_ovf_cnt);
    check_eq("sat_count", sat_count, m_sat_cnt);
    if (int'(fill) > max_fill) max_fill = int'(fill);
  endtask

  // called at a falling edge: drive, capture any read, clock, update model, check
  task automatic step(input bit v, input logic [IN_W-1:0] d, input bit rdy, input bit clr);
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    clr_stats = clr;
    #1;
    if (out_valid && out_ready) got_q.push_back(out_data);
    @(posedge clk);
    model_update(v, d, rdy, clr);
    @(negedge clk);
    check_all();
  endtask

  logic [IN_W-1:0]  t1_in  [5];
  logic [OUT_W-1:0] t1_exp [5];
  int               first_seen;

  initial begin
    t1_in  = '{24'h000600, 24'h000200, 24'h0001FF, 24'hFFFFFF, 24'hFFFDFF};
    t1_exp = '{14'd2, 14'd1, 14'd0, 14'd0, 14'h3FFF};
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr_stats = 1'b0;
    model_reset();
    max_fill = 0;
    #2;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_fill", fill, 0);
    check_eq("rst_ovf_flag", ovf_flag, 0);
    check_eq("rst_ovf_count", ovf_count, 0);
    check_eq("rst_sat_count", sat_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) step(0, '0, 1, 0);

    // rounding
    got_q.delete();
    for (int i = 0; i < 5; i++) step(1, t1_in[i], 1, 0);
    repeat (2) step(0, '0, 1, 0);
    check_eq("t1_count", got_q.size(), 5);
    for (int i = 0; i < 5 && i < got_q.size(); i++) check_eq("t1_round", got_q[i], t1_exp[i]);
    check_eq("t1_sat", sat_count, 0);

    // saturation
    got_q.delete();
    step(1, 24'h7FFFFF, 1, 0);
    check_eq("t2_sat_one", sat_count, 1);
    step(1, 24'h800000, 1, 0);
    check_eq("t2_sat_neg", sat_count, 1);
    repeat (2) step(0, '0, 1, 0);
    check_eq("t2_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check_eq("t2_pos", got_q[0], 14'h1FFF);
      check_eq("t2_neg", got_q[1], 14'h2000);
    end
    repeat (300) step(1, 24'h7FFFFF, 1, 0);
    repeat (2) step(0, '0, 1, 0);
    check_eq("t2_sat_cap", sat_count, 255);

    // latency and throughput
    got_q.delete();
    max_fill   = 0;
    first_seen = -1;
    for (int i = 0; i < 16; i++) begin
      step(1, IN_W'(i << SH), 1, 0);
      if (out_valid && first_seen < 0) first_seen = i;
    end
    repeat (2) step(0, '0, 1, 0);
    check_eq("t3_latency", first_seen, 1);
    check_eq("t3_count", got_q.size(), 16);
    for (int i = 0; i < got_q.size(); i++) check_eq("t3_order", got_q[i], i);
    check_eq("t3_max_fill_le2", max_fill <= 2, 1);

    // overflow
    step(0, '0, 1, 1);
    got_q.delete();
    for (int i = 1; i <= 10; i++) step(1, IN_W'(i << SH), 0, 0);
    step(0, '0, 0, 0);
    check_eq("t4_fill", fill, 8);
    check_eq("t4_ovf_flag", ovf_flag, 1);
    check_eq("t4_ovf_count", ovf_count, 2);
    repeat (10) step(0, '0, 1, 0);
    check_eq("t4_count", got_q.size(), 8);
    for (int i = 0; i < got_q.size(); i++) check_eq("t4_drain", got_q[i], i + 1);

    // full with simultaneous read
    got_q.delete();
    for (int i = 1; i <= 8; i++) step(1, IN_W'((i + 20) << SH), 0, 0);
    step(1, IN_W'(99 << SH), 0, 0);
    check_eq("t5_full", fill, 8);
    step(0, '0, 1, 0);
    check_eq("t5_fill_hold", fill, 8);
    check_eq("t5_ovf_count", ovf_count, 2);
    repeat (10) step(0, '0, 1, 0);
    check_eq("t5_count", got_q.size(), 9);
    for (int i = 0; i < 8 && i < got_q.size(); i++) check_eq("t5_order", got_q[i], i + 21);
    if (got_q.size() == 9) check_eq("t5_last", got_q[8], 99);

    // asynchronous reset mid-stream
    for (int i = 1; i <= 5; i++) step(1, IN_W'(i << SH), 0, 0);
    step(0, '0, 0, 0);
    check_eq("t6_pre_fill", fill, 5);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_rst_valid", out_valid, 0);
    check_eq("t6_rst_fill", fill, 0);
    check_eq("t6_rst_data", out_data, 0);
    check_eq("t6_rst_ovf_count", ovf_count, 0);
    check_eq("t6_rst_ovf_flag", ovf_flag, 0);
    check_eq("t6_rst_sat", sat_count, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step(0, '0, 1, 0);

    // clear coinciding with a drop
    for (int i = 1; i <= 9; i++) step(1, IN_W'(i << SH), 0, 0);
    step(0, '0, 0, 1);
    check_eq("t6_clr_flag", ovf_flag, 0);
    check_eq("t6_clr_count", ovf_count, 0);
    check_eq("t6_clr_fill", fill, 8);
    repeat (10) step(0, '0, 1, 0);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      logic [IN_W-1:0] d;
      case ($urandom_range(0, 3))
        0:       d = 24'h7FFE00 + IN_W'($urandom_range(0, 511));
        1:       d = 24'h800000 + IN_W'($urandom_range(0, 511));
        default: d = IN_W'($urandom);
      endcase
      step($urandom_range(0, 3) != 0, d, $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
    end
    repeat (12) step(0, '0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
